// File: rtl/is_pkg.sv
// Shared types and default sizing for the input-stationary datapath feeder.
package is_pkg;

  typedef enum logic [1:0] {
    IS_IDLE   = 2'd0,
    IS_LOAD_W = 2'd1,
    IS_DRAIN  = 2'd2
  } is_state_e;

  localparam int IS_LANES  = 16;
  localparam int IS_DW     = 32;
  localparam int IS_NUM_W  = 16;
  localparam int IS_LAT    = 18;
  localparam int IS_FIFO_D = 4;

endpackage

// File: rtl/is_result_fifo.sv
// Result FIFO with a registered output slot; o_count includes the entry shown on o_data.
module is_result_fifo
  import is_pkg::*;
#(
  parameter int DW     = IS_DW,
  parameter int FIFO_D = IS_FIFO_D,
  parameter int CW     = $clog2(FIFO_D + 1)
) (
  input  logic          IS_CLK,
  input  logic          IS_RSTN,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [CW-1:0] o_count
);

  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;

  logic [DW-1:0] r_mem [FIFO_D];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_mcnt;
  logic          r_valid;
  logic [DW-1:0] r_data;

  logic w_pop, w_load, w_mem_has, w_bypass, w_mem_wr, w_mem_rd;

  // The output slot refills from storage first; an empty FIFO lets a push go straight to it.
  assign w_pop     = r_valid && i_ready;
  assign w_load    = !r_valid || w_pop;
  assign w_mem_has = (r_mcnt != '0);
  assign w_bypass  = w_load && !w_mem_has && i_push;
  assign w_mem_wr  = i_push && !w_bypass;
  assign w_mem_rd  = w_load && w_mem_has;

  always_ff @(posedge IS_CLK) begin
    if (w_mem_wr) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge IS_CLK or negedge IS_RSTN) begin
    if (!IS_RSTN) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_mcnt  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (w_mem_wr) r_wr <= r_wr + PW'(1);
      if (w_mem_rd) r_rd <= r_rd + PW'(1);
      r_mcnt <= r_mcnt + CW'(w_mem_wr) - CW'(w_mem_rd);
      if (w_load) begin
        r_valid <= w_mem_has || i_push;
        if (w_mem_has) r_data <= r_mem[r_rd];
        else if (i_push) r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_count = r_mcnt + CW'(r_valid);

endmodule

// File: rtl/is_datapath_feeder.sv
// Sequences input/weight beats into the IS MAC datapath and collects column results.
// Optional IS_FEEDER_PERF_CNT_EN adds busy/stall performance counters.
module is_datapath_feeder
  import is_pkg::*;
#(
  parameter int LANES  = IS_LANES,
  parameter int DW     = IS_DW,
  parameter int NUM_W  = IS_NUM_W,
  parameter int LAT    = IS_LAT,
  parameter int FIFO_D = IS_FIFO_D
) (
  input  logic                   IS_CLK,
  input  logic                   IS_RSTN,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_is_weight,
  input  logic [LANES*DW-1:0]    s_data,
  output logic                   IS_clk_is_enable_o,
  output logic                   IS_enI_o,
  output logic                   IS_enW_o,
  output logic [LANES*DW-1:0]    IS_In_o,
  input  logic signed [DW-1:0]   IS_out_i,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic signed [DW-1:0]   m_data,
  output logic                   tile_done_o,
  output logic                   err_o,
  output logic [1:0]             o_dbg_state
`ifdef IS_FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]            perf_busy_o,
  output logic [31:0]            perf_stall_o
`endif
);

  localparam int WCW = $clog2(NUM_W + 1);
  localparam int CW  = $clog2(FIFO_D + 1);

  is_state_e             r_state;
  logic [WCW-1:0]        r_wcnt;
  logic [CW-1:0]         r_inflight;
  logic                  r_live;
  logic                  r_enI;
  logic                  r_enW;
  logic                  r_err;
  logic [LANES*DW-1:0]   r_in;
  logic [LAT-1:0]        r_sr;

  logic [CW-1:0] w_fifo_count;
  logic          w_credit_ok, w_fire, w_issue_i, w_issue_w, w_cap, w_last_w;
  logic [DW-1:0] w_m_data;

  // Results already queued plus those still in the pipe must fit in the FIFO.
  assign w_credit_ok = ((CW+1)'(w_fifo_count) + (CW+1)'(r_inflight)) < (CW+1)'(FIFO_D);

  always_comb begin
    s_ready = 1'b0;
    case (r_state)
      IS_IDLE:   s_ready = r_live;
      IS_LOAD_W: s_ready = s_is_weight && w_credit_ok;
      default:   s_ready = 1'b0;
    endcase
  end

  assign w_fire    = s_valid && s_ready;
  assign w_issue_i = w_fire && (r_state == IS_IDLE) && !s_is_weight;
  assign w_issue_w = w_fire && (r_state == IS_LOAD_W);
  assign w_cap     = r_sr[LAT-1];
  assign w_last_w  = (r_wcnt == WCW'(NUM_W - 1));

  always_ff @(posedge IS_CLK or negedge IS_RSTN) begin
    if (!IS_RSTN) begin
      r_state    <= IS_IDLE;
      r_wcnt     <= '0;
      r_inflight <= '0;
      r_live     <= 1'b0;
      r_enI      <= 1'b0;
      r_enW      <= 1'b0;
      r_err      <= 1'b0;
      r_in       <= '0;
      r_sr       <= '0;
    end else begin
      r_live <= 1'b1;
      r_enI  <= w_issue_i;
      r_enW  <= w_issue_w;
      if (w_issue_i || w_issue_w) r_in <= s_data;
      r_sr <= {r_sr[LAT-2:0], r_enW};
      if (w_issue_w && !w_cap) r_inflight <= r_inflight + CW'(1);
      else if (!w_issue_w && w_cap) r_inflight <= r_inflight - CW'(1);
      case (r_state)
        IS_IDLE: begin
          if (w_fire) begin
            if (s_is_weight) r_err <= 1'b1;
            else begin
              r_state <= IS_LOAD_W;
              r_wcnt  <= '0;
            end
          end
        end
        IS_LOAD_W: begin
          if (w_issue_w) begin
            r_wcnt <= r_wcnt + WCW'(1);
            if (w_last_w) r_state <= IS_DRAIN;
          end
        end
        IS_DRAIN: begin
          if (r_inflight == '0) r_state <= IS_IDLE;
        end
        default: r_state <= IS_IDLE;
      endcase
    end
  end

  assign IS_enI_o           = r_enI;
  assign IS_enW_o           = r_enW;
  assign IS_In_o            = r_in;
  assign err_o              = r_err;
  assign tile_done_o        = (r_state == IS_DRAIN) && (r_inflight == '0);
  assign IS_clk_is_enable_o = (r_state != IS_IDLE) || (r_inflight != '0);
  assign o_dbg_state        = r_state;
  assign m_data             = w_m_data;

  is_result_fifo #(
    .DW     (DW),
    .FIFO_D (FIFO_D),
    .CW     (CW)
  ) u_fifo (
    .IS_CLK  (IS_CLK),
    .IS_RSTN (IS_RSTN),
    .i_push  (w_cap),
    .i_data  (IS_out_i),
    .i_ready (m_ready),
    .o_valid (m_valid),
    .o_data  (w_m_data),
    .o_count (w_fifo_count)
  );

`ifdef IS_FEEDER_PERF_CNT_EN
  logic [31:0] r_perf_busy;
  logic [31:0] r_perf_stall;

  always_ff @(posedge IS_CLK or negedge IS_RSTN) begin
    if (!IS_RSTN) begin
      r_perf_busy  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (IS_clk_is_enable_o) r_perf_busy <= r_perf_busy + 32'd1;
      if ((r_state == IS_LOAD_W) && s_valid && s_is_weight && !w_credit_ok)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_busy_o  = r_perf_busy;
  assign perf_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_is_datapath_feeder.sv
// Self-checking bench for is_datapath_feeder: queue-based reference model plus directed tiles.
module tb_is_datapath_feeder;

  localparam int LANES  = 16;
  localparam int DW     = 32;
  localparam int NUM_W  = 16;
  localparam int LAT    = 18;
  localparam int FIFO_D = 4;
  localparam int BW     = LANES * DW;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic          s_valid, s_ready, s_is_weight;
  logic [BW-1:0] s_data;
  logic          en_o, eni_o, enw_o;
  logic [BW-1:0] in_o;
  logic [DW-1:0] out_i;
  logic          m_valid, m_ready;
  logic [DW-1:0] m_data;
  logic          tile_done, err;
  logic [1:0]    dbg_state;
`ifdef IS_FEEDER_PERF_CNT_EN
  logic [31:0]   perf_busy, perf_stall;
`endif

  is_datapath_feeder #(
    .LANES(LANES), .DW(DW), .NUM_W(NUM_W), .LAT(LAT), .FIFO_D(FIFO_D)
  ) dut (
    .IS_CLK             (clk),
    .IS_RSTN            (rstn),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .s_is_weight        (s_is_weight),
    .s_data             (s_data),
    .IS_clk_is_enable_o (en_o),
    .IS_enI_o           (eni_o),
    .IS_enW_o           (enw_o),
    .IS_In_o            (in_o),
    .IS_out_i           (out_i),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .m_data             (m_data),
    .tile_done_o        (tile_done),
    .err_o              (err),
    .o_dbg_state        (dbg_state)
`ifdef IS_FEEDER_PERF_CNT_EN
    ,
    .perf_busy_o        (perf_busy),
    .perf_stall_o       (perf_stall)
`endif
  );

  // scoreboard / model state
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int md = 0;            // 0 idle, 1 loading weights, 2 draining
  int wc = 0;
  int pend[$];           // capture cycle of each issued, uncaptured weight
  logic [DW-1:0] exp_q[$];
  logic [BW-1:0] m_in = '0;
  bit m_enI = 0, m_enW = 0, m_err = 0, m_live = 0, e_credit = 0, e_ready = 0;
  int busy_cnt = 0, stall_cnt = 0, m_tiles = 0;
  int obs_enw = 0, obs_eni = 0, obs_done = 0, obs_res = 0;
  int b_enw, b_eni, b_done, b_res;

  // stimulus policy
  int pol_valid = 0, pol_wpct = 0, pol_mready = 100, inputs_left = 0;
  bit pol_smart = 1;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic snap();
    b_enw = obs_enw; b_eni = obs_eni; b_done = obs_done; b_res = obs_res;
  endtask

  task automatic drive();
    s_valid = ($urandom_range(99) < pol_valid);
    if (pol_smart) begin
      s_is_weight = (md != 0);
      if (md == 0 && inputs_left == 0) s_valid = 1'b0;
    end else begin
      s_is_weight = ($urandom_range(99) < pol_wpct);
    end
    for (int i = 0; i < LANES; i++) s_data[i*DW +: DW] = $urandom();
    m_ready = ($urandom_range(99) < pol_mready);
    out_i = $urandom();
  endtask

  // per-cycle compare of every output against the model
  task automatic check_cycle();
    e_credit = (exp_q.size() + pend.size()) < FIFO_D;
    case (md)
      0:       e_ready = m_live;
      1:       e_ready = s_is_weight && e_credit;
      default: e_ready = 1'b0;
    endcase
    chk("s_ready", BW'(s_ready), BW'(e_ready));
    chk("enI", BW'(eni_o), BW'(m_enI));
    chk("enW", BW'(enw_o), BW'(m_enW));
    chk("In_bus", in_o, m_in);
    chk("enable", BW'(en_o), BW'(md != 0 || pend.size() != 0));
    chk("m_valid", BW'(m_valid), BW'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("m_data", BW'(m_data), BW'(exp_q[0]));
    chk("tile_done", BW'(tile_done), BW'(md == 2 && pend.size() == 0));
    chk("err", BW'(err), BW'(m_err));
    if (enw_o) obs_enw++;
    if (eni_o) obs_eni++;
    if (tile_done) obs_done++;
    if (m_valid && m_ready) obs_res++;
  endtask

  task automatic update();
    bit fire, pend_empty, cap;
    logic [DW-1:0] cv;
    fire = s_valid && e_ready;
    pend_empty = (pend.size() == 0);
    cap = 1'b0;
    cv = '0;
    if (!pend_empty && pend[0] == cyc) begin
      void'(pend.pop_front());
      cap = 1'b1;
      cv = out_i;
    end
    if (exp_q.size() > 0 && m_ready) void'(exp_q.pop_front());
    if (cap) exp_q.push_back(cv);
    if (md != 0 || !pend_empty) busy_cnt++;
    if (md == 1 && s_valid && s_is_weight && !e_credit) stall_cnt++;
    m_enI = 1'b0;
    m_enW = 1'b0;
    case (md)
      0: if (fire) begin
        if (s_is_weight) m_err = 1'b1;
        else begin
          md = 1; wc = 0; m_enI = 1'b1; m_in = s_data;
          if (inputs_left > 0) inputs_left--;
        end
      end
      1: if (fire) begin
        m_enW = 1'b1; m_in = s_data;
        pend.push_back(cyc + 1 + LAT);
        wc++;
        if (wc == NUM_W) md = 2;
      end
      default: if (pend_empty) begin md = 0; m_tiles++; end
    endcase
    m_live = 1'b1;
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    check_cycle();
    @(posedge clk);
    update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    chk("rst_s_ready", BW'(s_ready), '0);
    chk("rst_m_valid", BW'(m_valid), '0);
    chk("rst_m_data", BW'(m_data), '0);
    chk("rst_In_bus", in_o, '0);
    chk("rst_enI", BW'(eni_o), '0);
    chk("rst_enW", BW'(enw_o), '0);
    chk("rst_enable", BW'(en_o), '0);
    chk("rst_tile_done", BW'(tile_done), '0);
    chk("rst_err", BW'(err), '0);
    md = 0; wc = 0; pend.delete(); exp_q.delete(); m_in = '0;
    m_enI = 0; m_enW = 0; m_err = 0; m_live = 0; busy_cnt = 0; stall_cnt = 0;
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic run_tiles(input int target, input int limit);
    int k = 0;
    while (m_tiles < target && k < limit) begin step(); k++; end
    if (m_tiles < target) chk("tile_timeout", BW'(m_tiles), BW'(target));
    k = 0;
    while (exp_q.size() > 0 && k < 60) begin step(); k++; end
  endtask

  task automatic chk_perf();
`ifdef IS_FEEDER_PERF_CNT_EN
    #1;
    chk("perf_busy", BW'(perf_busy), BW'(busy_cnt));
    chk("perf_stall", BW'(perf_stall), BW'(stall_cnt));
`endif
  endtask

  initial begin
    s_valid = 0; s_is_weight = 0; s_data = '0; m_ready = 0; out_i = '0;
    do_reset();

    // one full tile, consumer always ready
    pol_smart = 1; pol_valid = 100; pol_mready = 100; inputs_left = 1;
    snap();
    run_tiles(m_tiles + 1, 400);
    chk("t1_eni", BW'(obs_eni - b_eni), BW'(1));
    chk("t1_enw", BW'(obs_enw - b_enw), BW'(NUM_W));
    chk("t1_results", BW'(obs_res - b_res), BW'(NUM_W));
    chk("t1_done", BW'(obs_done - b_done), BW'(1));

    // consumer stalled: credit stops issue after FIFO_D weights
    pol_mready = 0; inputs_left = 1;
    snap();
    repeat (60) step();
    chk("t2_enw_stalled", BW'(obs_enw - b_enw), BW'(FIFO_D));
    chk("t2_no_results", BW'(obs_res - b_res), BW'(0));
    pol_mready = 100;
    run_tiles(m_tiles + 1, 600);
    chk("t2_enw", BW'(obs_enw - b_enw), BW'(NUM_W));
    chk("t2_results", BW'(obs_res - b_res), BW'(NUM_W));
    chk("t2_done", BW'(obs_done - b_done), BW'(1));
    chk_perf();

    // reset after the fifth weight, then a clean tile
    inputs_left = 1;
    snap();
    begin
      int k = 0;
      while (obs_enw - b_enw < 5 && k < 300) begin step(); k++; end
      chk("t5_reach_5w", BW'(obs_enw - b_enw), BW'(5));
    end
    do_reset();
    inputs_left = 1;
    snap();
    run_tiles(m_tiles + 1, 400);
    chk("t5_enw", BW'(obs_enw - b_enw), BW'(NUM_W));
    chk("t5_results", BW'(obs_res - b_res), BW'(NUM_W));
    chk("t5_done", BW'(obs_done - b_done), BW'(1));

    // weight beat in IDLE is dropped and flags an error
    pol_smart = 0; pol_wpct = 100; pol_valid = 100;
    snap();
    step();
    pol_valid = 0;
    repeat (3) step();
    #1;
    chk("t3_err_sticky", BW'(err), BW'(1));
    chk("t3_no_strobe", BW'(obs_enw - b_enw + obs_eni - b_eni), BW'(0));

    // randomized traffic, mixed beat types and back-pressure
    pol_smart = 0; pol_valid = 70; pol_wpct = 75; pol_mready = 60; inputs_left = 1000000;
    repeat (3000) step();
    pol_valid = 0; pol_mready = 100;
    repeat (100) step();
    chk_perf();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
